// File: rtl/bnn_neuron_accum_if.sv
// Beat stream in, neuron result out, between the fetch FSM and the activation store.
interface bnn_neuron_accum_if #(
  parameter int unsigned ACC_W = 12,
  parameter int unsigned IDX_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic             w_bit;
  logic             x_bit;
  logic             in_last;
  logic             out_valid;
  logic [ACC_W-1:0] acc_out;
  logic             act_out;
  logic             len_err;
  logic [IDX_W-1:0] neuron_idx;
  logic             layer_done;

  modport master (
    output in_valid, w_bit, x_bit, in_last,
    input  in_ready, out_valid, acc_out, act_out, len_err, neuron_idx, layer_done
  );

  modport slave (
    input  in_valid, w_bit, x_bit, in_last,
    output in_ready, out_valid, acc_out, act_out, len_err, neuron_idx, layer_done
  );
endinterface

// File: rtl/bnn_neuron_accum.sv
// Binary neuron: XNOR-popcount over N_IN beats, then emits popcount, sign activation
// and length error, tracking the neuron index within the layer.
module bnn_neuron_accum #(
  parameter int unsigned N_IN   = 784,
  parameter int unsigned N_OUT  = 1024,
  parameter int unsigned ACC_W  = 12,
  parameter int unsigned IDX_W  = 10,
  parameter int unsigned THRESH = 392
) (
  input logic                clk,
  input logic                rst,
  bnn_neuron_accum_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(N_IN + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx, acc_sum, acc_out_nx;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nx;
  logic [IDX_W-1:0] idx_nx;
  logic             ready_nx, valid_nx, act_nx, len_err_nx, layer_done_nx;
  logic             accept, terminal, match;

  assign accept   = bus.in_valid & bus.in_ready;
  assign match    = ~(bus.w_bit ^ bus.x_bit);
  assign terminal = bus.in_last | (beat_cnt == CNT_W'(N_IN - 1));
  // Saturating add; only reachable with an undersized ACC_W.
  assign acc_sum  = (acc == '1) ? acc : acc + ACC_W'(match);

  // Next-state and next-output logic; result fields hold unless a neuron finishes.
  always_comb begin
    state_nx      = state;
    acc_nx        = acc;
    beat_cnt_nx   = beat_cnt;
    idx_nx        = bus.neuron_idx;
    valid_nx      = 1'b0;
    layer_done_nx = 1'b0;
    acc_out_nx    = bus.acc_out;
    act_nx        = bus.act_out;
    len_err_nx    = bus.len_err;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          if (terminal) begin
            state_nx      = EMIT;
            acc_nx        = '0;
            beat_cnt_nx   = '0;
            valid_nx      = 1'b1;
            acc_out_nx    = acc_sum;
            act_nx        = (acc_sum >= ACC_W'(THRESH));
            len_err_nx    = (beat_cnt != CNT_W'(N_IN - 1));
            layer_done_nx = (bus.neuron_idx == IDX_W'(N_OUT - 1));
          end else begin
            state_nx    = ACCUM;
            acc_nx      = acc_sum;
            beat_cnt_nx = beat_cnt + CNT_W'(1);
          end
        end
      end
      EMIT: begin
        state_nx = IDLE;
        idx_nx   = (bus.neuron_idx == IDX_W'(N_OUT - 1)) ? '0 : bus.neuron_idx + IDX_W'(1);
      end
      default: state_nx = IDLE;
    endcase
    ready_nx = (state_nx != EMIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      acc            <= '0;
      beat_cnt       <= '0;
      bus.in_ready   <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.acc_out    <= '0;
      bus.act_out    <= 1'b0;
      bus.len_err    <= 1'b0;
      bus.neuron_idx <= '0;
      bus.layer_done <= 1'b0;
    end else begin
      state          <= state_nx;
      acc            <= acc_nx;
      beat_cnt       <= beat_cnt_nx;
      bus.in_ready   <= ready_nx;
      bus.out_valid  <= valid_nx;
      bus.acc_out    <= acc_out_nx;
      bus.act_out    <= act_nx;
      bus.len_err    <= len_err_nx;
      bus.neuron_idx <= idx_nx;
      bus.layer_done <= layer_done_nx;
    end
  end
endmodule

// File: tb/tb_bnn_neuron_accum.sv
// Directed bench for bnn_neuron_accum (N_OUT overridden to 4) with a result scoreboard.
module tb_bnn_neuron_accum;
  localparam int unsigned N_IN   = 784;
  localparam int unsigned N_OUT  = 4;
  localparam int unsigned ACC_W  = 12;
  localparam int unsigned IDX_W  = 10;
  localparam int unsigned THRESH = 392;

  typedef struct {
    int unsigned acc;
    int unsigned act;
    int unsigned len_err;
    int unsigned idx;
    int unsigned layer_done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned exp_idx = 0;
  exp_t sb[$];

  bnn_neuron_accum_if #(.ACC_W(ACC_W), .IDX_W(IDX_W)) bus ();

  bnn_neuron_accum #(
    .N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_W), .IDX_W(IDX_W), .THRESH(THRESH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard: every out_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("acc_out",    32'(bus.acc_out),    e.acc);
        check("act_out",    32'(bus.act_out),    e.act);
        check("len_err",    32'(bus.len_err),    e.len_err);
        check("neuron_idx", 32'(bus.neuron_idx), e.idx);
        check("layer_done", 32'(bus.layer_done), e.layer_done);
      end
    end else if (!rst && bus.layer_done === 1'b1) begin
      check("layer_done_without_valid", 1, 0);
    end
  end

  // One beat, held until accepted; accepted on the following rising edge.
  task automatic drive_beat(input logic w, input logic x, input logic last, output bit ok);
    int unsigned budget = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.w_bit    = w;
    bus.x_bit    = x;
    bus.in_last  = last;
    while (bus.in_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    ok = (budget < 50);
    if (!ok) begin
      check("in_ready_timeout", 0, 1);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  // First n_match beats match (w=x=1), the rest mismatch (w=1,x=0).
  task automatic send_neuron(input int unsigned n_beats, input int unsigned n_match,
                             input bit use_last);
    bit ok;
    bit terminal;
    exp_t e;
    for (int i = 0; i < int'(n_beats); i++) begin
      terminal = (i == int'(n_beats) - 1) && (use_last || n_beats == N_IN);
      if (i == 100) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
      end
      if (terminal) begin
        e.acc        = n_match;
        e.act        = (n_match >= THRESH) ? 1 : 0;
        e.len_err    = (n_beats != N_IN) ? 1 : 0;
        e.idx        = exp_idx;
        e.layer_done = (exp_idx == N_OUT - 1) ? 1 : 0;
        sb.push_back(e);
        exp_idx = (exp_idx + 1) % N_OUT;
      end
      drive_beat(1'b1, (i < int'(n_match)), use_last && (i == int'(n_beats) - 1), ok);
      if (!ok) return;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (terminal) check("latency_out_valid", 32'(bus.out_valid), 1);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.w_bit    = 1'b0;
    bus.x_bit    = 1'b0;
    bus.in_last  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid",  32'(bus.out_valid),  0);
    check("rst_acc_out",    32'(bus.acc_out),    0);
    check("rst_in_ready",   32'(bus.in_ready),   0);
    check("rst_neuron_idx", 32'(bus.neuron_idx), 0);
    rst = 1'b0;

    send_neuron(N_IN, N_IN, 1'b1);      // all match, idx 0
    send_neuron(N_IN, 0, 1'b1);         // no match, idx 1
    send_neuron(N_IN, THRESH, 1'b1);    // exactly at threshold
    send_neuron(N_IN, THRESH - 1, 1'b1);// one below, idx 3 -> layer_done
    send_neuron(10, 10, 1'b1);          // early in_last, idx wraps to 0
    send_neuron(N_IN, 500, 1'b0);       // N_IN reached without in_last
    send_neuron(1, 1, 1'b1);            // in_last on first beat
    check("acc_out_held", 32'(bus.acc_out), 1);

    // Partial neuron, then async reset between clock edges.
    send_neuron(300, 300, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid",  32'(bus.out_valid),  0);
    check("arst_acc_out",    32'(bus.acc_out),    0);
    check("arst_act_out",    32'(bus.act_out),    0);
    check("arst_len_err",    32'(bus.len_err),    0);
    check("arst_neuron_idx", 32'(bus.neuron_idx), 0);
    check("arst_layer_done", 32'(bus.layer_done), 0);
    check("arst_in_ready",   32'(bus.in_ready),   0);
    @(negedge clk);
    rst = 1'b0;
    exp_idx = 0;

    send_neuron(N_IN, 500, 1'b1);
    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
